nts_tx_buffer_multi: RTL and testbench
======================================

NTS_TX_BUFFER_MULTI -- requirements
Module: nts_tx_buffer_multi

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-address width per bank (bank depth 2^ADDR_WIDTH 64-bit words).
REQ-002 SHALL have parameter BANK_BITS, default 2, meaning log2 of bank count (BANKS = 2^BANK_BITS, legal BANK_BITS 1..3).
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, all logic on rising edge.
- i_areset  in  1  reset, synchronous and active-high.
- i_write_en  in  1  parser word write strobe.
- i_write_data  in  64  parser write word.
- i_address_internal  in  1  1: write at internal append pointer; 0: write at i_address_hi.
- i_address_hi  in  ADDR_WIDTH  word address (external writes) / length high part.
- i_address_lo  in  3  length low part (bytes).
- i_parser_update_length  in  1  load packet length from i_address_hi/lo.
- i_parser_done  in  1  current packet complete, hand to dispatch.
- i_parser_clear  in  1  discard current parser bank contents.
- o_parser_ready  out  1  current parser bank accepts writes.
- o_parser_current_empty  out  1  current parser bank EMPTY.
- o_parser_current_memory_full  out  1  next internal write would overrun.
- o_dispatch_tx_packet_available  out  1  read bank holds a complete packet.
- o_dispatch_tx_fifo_empty  out  1  all words of read packet fetched.
- i_dispatch_tx_fifo_rd_en  in  1  fetch next word.
- o_dispatch_tx_fifo_rd_data  out  64  fetched word.
- o_dispatch_tx_bytes_last_word  out  4  valid bytes in last word (0..8).
- i_dispatch_tx_packet_read  in  1  release read bank.
- o_packets_queued  out  BANK_BITS+1  complete packets awaiting dispatch.
- o_error  out  1  sticky overrun/protocol error.

Function
REQ-004 Each bank SHALL hold state EMPTY, WRITING, QUEUED; banks SHALL be used strictly round-robin by wr_bank and rd_bank pointers (mod BANKS).
REQ-005 o_parser_ready SHALL be 1 iff bank[wr_bank] is EMPTY or WRITING; o_parser_current_empty iff EMPTY.
REQ-006 Accepted internal write: word stored at wr_ptr, wr_ptr increments, bank EMPTY->WRITING; first write after EMPTY SHALL land at address 0.
REQ-007 Accepted external write: word stored at i_address_hi, wr_ptr unchanged, EMPTY->WRITING.
REQ-008 Write with o_parser_ready=0, or internal write with wr_ptr already wrapped past 2^ADDR_WIDTH-1 (overflow flag set), SHALL be dropped and set o_error.
REQ-009 o_parser_current_memory_full SHALL be 1 when the overflow flag is set or o_parser_ready=0.
REQ-010 i_parser_update_length: len = i_address_hi*8 + i_address_lo; word_count = ceil(len/8); bytes_last_word = 0 if len=0, 8 if i_address_lo=0, else i_address_lo; latched for wr_bank; last update before done wins.
REQ-011 Without any update_length, done SHALL set word_count = wr_ptr (count including overflow at full depth = 2^ADDR_WIDTH), bytes_last_word = 8 (0 if word_count=0).
REQ-012 i_parser_done with bank WRITING: bank->QUEUED, wr_bank increments, wr_ptr and overflow flag clear, next cycle; done while EMPTY SHALL be ignored.
REQ-013 i_parser_clear SHALL return bank[wr_bank] to EMPTY, clear wr_ptr, length and overflow; clear has priority over write, update_length and done in the same cycle; clear does not clear o_error.
REQ-014 o_dispatch_tx_packet_available = (bank[rd_bank]==QUEUED).
REQ-015 rd_en while available and not fifo_empty: word at rd_ptr SHALL appear on rd_data exactly 1 cycle later and hold until next accepted fetch; rd_ptr increments.
REQ-016 o_dispatch_tx_fifo_empty = !available or rd_ptr == word_count[rd_bank]; rd_en while fifo_empty SHALL be ignored.
REQ-017 o_dispatch_tx_bytes_last_word SHALL show bytes_last_word[rd_bank] while available, else 0.
REQ-018 i_dispatch_tx_packet_read while available: bank->EMPTY, rd_bank increments, rd_ptr clears; packet_read when not available SHALL set o_error and change nothing else.
REQ-019 Done and packet_read in the same cycle SHALL both take effect; o_packets_queued SHALL then be unchanged.
REQ-020 wr_bank reaching a QUEUED bank SHALL block writes (o_parser_ready=0) until dispatch releases it.

Reset
REQ-021 While i_areset=1 at a clock edge: all banks EMPTY, wr_bank=rd_bank=0, all pointers/lengths/overflow 0, o_error=0, rd_data=0; outputs next cycle: ready=1, current_empty=1, available=0, fifo_empty=1, packets_queued=0, memory_full=0.
REQ-022 Reset mid-write or mid-read SHALL discard all packets; RAM contents need not be cleared.

Verification
REQ-023 Write 3 words internal, update_length hi=2 lo=5, done -> available=1, bytes_last_word=5, three rd_en yield words 0..2 each 1 cycle later, then fifo_empty=1.
REQ-024 BANKS=4: queue 4 packets without reads -> packets_queued=4, ready=0; further write sets o_error; one packet_read -> ready=1, packets_queued=3.
REQ-025 ADDR_WIDTH=3: 8 internal writes -> memory_full=1; 9th dropped, o_error=1; done -> word_count 8 delivered intact.
REQ-026 Clear asserted with write and done same cycle -> bank EMPTY, nothing queued, available stays 0.
REQ-027 Done on bank 1 and packet_read on bank 0 same cycle -> packets_queued unchanged, rd_bank=1, available=1.
REQ-028 Reset asserted mid-read after 1 of 4 words -> all REQ-021 values next cycle; new packet afterwards starts at bank 0 address 0.

Source files
------------

// File: rtl/nts_tx_buffer_multi.sv
`default_nettype none
// ============================================================================
// Module      : nts_tx_buffer_multi
// Description : Multi-bank transmit packet buffer. A parser fills one bank at
//               a time (internal append pointer or explicit word address),
//               sets an optional byte length and hands the bank to dispatch.
//               Dispatch drains complete packets word by word, in the same
//               round-robin bank order, and releases each bank when done.
//
// Ports       :
//   i_clk                          sole clock, rising edge
//   i_areset                       synchronous active-high reset
//   i_write_en / i_write_data      parser word write strobe / 64-bit word
//   i_address_internal             1: append at wr_ptr, 0: write at i_address_hi
//   i_address_hi / i_address_lo    word address, or packet length hi/lo part
//   i_parser_update_length         latch length from i_address_hi/lo
//   i_parser_done                  hand current bank to dispatch
//   i_parser_clear                 discard current parser bank
//   o_parser_ready                 current parser bank accepts writes
//   o_parser_current_empty         current parser bank is EMPTY
//   o_parser_current_memory_full   next internal write would overrun
//   o_dispatch_tx_packet_available read bank holds a complete packet
//   o_dispatch_tx_fifo_empty       every word of the read packet fetched
//   i_dispatch_tx_fifo_rd_en       fetch next word
//   o_dispatch_tx_fifo_rd_data     fetched word (one cycle after rd_en)
//   o_dispatch_tx_bytes_last_word  valid bytes in last word (0..8)
//   i_dispatch_tx_packet_read      release read bank
//   o_packets_queued               complete packets awaiting dispatch
//   o_error                        sticky overrun / protocol error
//
// Revision    : 1.0 - initial release
// ============================================================================
module nts_tx_buffer_multi #(
    parameter int ADDR_WIDTH = 8,
    parameter int BANK_BITS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_write_en,
    input  logic [63:0]           i_write_data,
    input  logic                  i_address_internal,
    input  logic [ADDR_WIDTH-1:0] i_address_hi,
    input  logic [2:0]            i_address_lo,
    input  logic                  i_parser_update_length,
    input  logic                  i_parser_done,
    input  logic                  i_parser_clear,
    output logic                  o_parser_ready,
    output logic                  o_parser_current_empty,
    output logic                  o_parser_current_memory_full,
    output logic                  o_dispatch_tx_packet_available,
    output logic                  o_dispatch_tx_fifo_empty,
    input  logic                  i_dispatch_tx_fifo_rd_en,
    output logic [63:0]           o_dispatch_tx_fifo_rd_data,
    output logic [3:0]            o_dispatch_tx_bytes_last_word,
    input  logic                  i_dispatch_tx_packet_read,
    output logic [BANK_BITS:0]    o_packets_queued,
    output logic                  o_error
);

    localparam int c_BANKS = 1 << BANK_BITS;
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Per-bank state encoding
    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_WRITING = 2'd1;
    localparam logic [1:0] c_ST_QUEUED  = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            bank_state_q   [c_BANKS];
    logic [1:0]            bank_state_d   [c_BANKS];
    logic [ADDR_WIDTH:0]   word_count_q   [c_BANKS];
    logic [ADDR_WIDTH:0]   word_count_d   [c_BANKS];
    logic [3:0]            bytes_last_q   [c_BANKS];
    logic [3:0]            bytes_last_d   [c_BANKS];

    logic [BANK_BITS-1:0]  wr_bank_q, wr_bank_d;
    logic [BANK_BITS-1:0]  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  len_set_q, len_set_d;
    logic [ADDR_WIDTH:0]   len_wc_q, len_wc_d;
    logic [3:0]            len_blw_q, len_blw_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [BANK_BITS:0]    queued_q, queued_d;
    logic                  error_q, error_d;
    logic                  rd_data_zero_q, rd_data_zero_d;

    // Packet storage, addressed {bank, word}. Not reset.
    logic [63:0]           ram_q [c_BANKS*c_DEPTH];
    logic [63:0]           ram_rd_q;

    // ------------------------------------------------------------------
    // Decode of current parser / dispatch conditions (FSM outputs)
    // ------------------------------------------------------------------
    logic [1:0]            w_wr_state;
    logic                  w_ready;
    logic                  w_cur_empty;
    logic                  w_avail;
    logic                  w_fifo_empty;

    always_comb begin
        w_wr_state   = bank_state_q[wr_bank_q];
        w_ready      = (w_wr_state == c_ST_EMPTY) || (w_wr_state == c_ST_WRITING);
        w_cur_empty  = (w_wr_state == c_ST_EMPTY);
        w_avail      = (bank_state_q[rd_bank_q] == c_ST_QUEUED);
        w_fifo_empty = !w_avail || (rd_ptr_q == word_count_q[rd_bank_q]);
    end

    // ------------------------------------------------------------------
    // Accept / reject decisions. Clear overrides every other parser action
    // in the same cycle, and a write lost to a clear is not an error.
    // ------------------------------------------------------------------
    logic                  w_wr_blocked;
    logic                  w_wr_ok;
    logic                  w_wr_drop;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_ptr_after;
    logic                  w_ovf_after;
    logic                  w_upd;
    logic [ADDR_WIDTH:0]   w_upd_wc;
    logic [3:0]            w_upd_blw;
    logic                  w_done;
    logic [ADDR_WIDTH:0]   w_fin_wc;
    logic [3:0]            w_fin_blw;
    logic                  w_fetch;
    logic                  w_release;
    logic                  w_bad_release;

    always_comb begin
        w_wr_blocked  = !w_ready || (i_address_internal && overflow_q);
        w_wr_ok       = i_write_en && !i_parser_clear && !w_wr_blocked;
        w_wr_drop     = i_write_en && !i_parser_clear && w_wr_blocked;
        w_wr_addr     = i_address_internal ? wr_ptr_q : i_address_hi;

        // Append pointer after this cycle's write; wrapping past the last
        // word raises the overflow flag, which doubles as the count MSB.
        w_ptr_inc     = w_wr_ok && i_address_internal;
        w_ptr_after   = wr_ptr_q + ADDR_WIDTH'(w_ptr_inc);
        w_ovf_after   = overflow_q || (w_ptr_inc && (wr_ptr_q == {ADDR_WIDTH{1'b1}}));

        w_upd         = i_parser_update_length && !i_parser_clear && w_ready;
        w_upd_wc      = {1'b0, i_address_hi} + (ADDR_WIDTH+1)'(i_address_lo != 3'd0);
        if ((i_address_hi == '0) && (i_address_lo == 3'd0)) begin
            w_upd_blw = 4'd0;
        end else if (i_address_lo == 3'd0) begin
            w_upd_blw = 4'd8;
        end else begin
            w_upd_blw = {1'b0, i_address_lo};
        end

        w_done        = i_parser_done && !i_parser_clear && (w_wr_state == c_ST_WRITING);

        // Length committed at done: a same-cycle update wins, then a latched
        // update, otherwise the append pointer with full last word.
        if (w_upd) begin
            w_fin_wc  = w_upd_wc;
            w_fin_blw = w_upd_blw;
        end else if (len_set_q) begin
            w_fin_wc  = len_wc_q;
            w_fin_blw = len_blw_q;
        end else begin
            w_fin_wc  = {w_ovf_after, w_ptr_after};
            w_fin_blw = (w_fin_wc == '0) ? 4'd0 : 4'd8;
        end

        w_fetch       = i_dispatch_tx_fifo_rd_en && !w_fifo_empty;
        w_release     = i_dispatch_tx_packet_read && w_avail;
        w_bad_release = i_dispatch_tx_packet_read && !w_avail;
    end

    // ------------------------------------------------------------------
    // Bank FSM next state. A clear never touches a QUEUED bank: that
    // packet already belongs to dispatch and is counted in packets_queued.
    // Done and release always target different banks (WRITING vs QUEUED).
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < c_BANKS; b++) begin
            bank_state_d[b] = bank_state_q[b];
            if (BANK_BITS'(b) == wr_bank_q) begin
                if (i_parser_clear) begin
                    if (bank_state_q[b] != c_ST_QUEUED) begin
                        bank_state_d[b] = c_ST_EMPTY;
                    end
                end else if (w_done) begin
                    bank_state_d[b] = c_ST_QUEUED;
                end else if (w_wr_ok) begin
                    bank_state_d[b] = c_ST_WRITING;
                end
            end
            if ((BANK_BITS'(b) == rd_bank_q) && w_release) begin
                bank_state_d[b] = c_ST_EMPTY;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = w_ptr_after;
        overflow_d = w_ovf_after;
        len_set_d  = len_set_q;
        len_wc_d   = len_wc_q;
        len_blw_d  = len_blw_q;
        if (w_upd) begin
            len_set_d = 1'b1;
            len_wc_d  = w_upd_wc;
            len_blw_d = w_upd_blw;
        end
        if (i_parser_clear || w_done) begin
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
            len_set_d  = 1'b0;
            len_wc_d   = '0;
            len_blw_d  = 4'd0;
        end
        wr_bank_d = wr_bank_q + BANK_BITS'(w_done);

        for (int b = 0; b < c_BANKS; b++) begin
            word_count_d[b] = word_count_q[b];
            bytes_last_d[b] = bytes_last_q[b];
            if (w_done && (BANK_BITS'(b) == wr_bank_q)) begin
                word_count_d[b] = w_fin_wc;
                bytes_last_d[b] = w_fin_blw;
            end
        end

        if (w_release) begin
            rd_ptr_d = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(w_fetch);
        end
        rd_bank_d = rd_bank_q + BANK_BITS'(w_release);

        queued_d       = queued_q + (BANK_BITS+1)'(w_done) - (BANK_BITS+1)'(w_release);
        error_d        = error_q || w_wr_drop || w_bad_release;
        rd_data_zero_d = rd_data_zero_q && !w_fetch;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            for (int b = 0; b < c_BANKS; b++) begin
                bank_state_q[b] <= c_ST_EMPTY;
                word_count_q[b] <= '0;
                bytes_last_q[b] <= 4'd0;
            end
            wr_bank_q      <= '0;
            rd_bank_q      <= '0;
            wr_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            len_set_q      <= 1'b0;
            len_wc_q       <= '0;
            len_blw_q      <= 4'd0;
            rd_ptr_q       <= '0;
            queued_q       <= '0;
            error_q        <= 1'b0;
            rd_data_zero_q <= 1'b1;
        end else begin
            for (int b = 0; b < c_BANKS; b++) begin
                bank_state_q[b] <= bank_state_d[b];
                word_count_q[b] <= word_count_d[b];
                bytes_last_q[b] <= bytes_last_d[b];
            end
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_ptr_q       <= wr_ptr_d;
            overflow_q     <= overflow_d;
            len_set_q      <= len_set_d;
            len_wc_q       <= len_wc_d;
            len_blw_q      <= len_blw_d;
            rd_ptr_q       <= rd_ptr_d;
            queued_q       <= queued_d;
            error_q        <= error_d;
            rd_data_zero_q <= rd_data_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Packet RAM: one write port (parser bank), one registered read port
    // (dispatch bank). The two banks are never the same one, so there is
    // no read/write collision. The read register has no reset so the RAM
    // can map onto block memory; rd_data_zero_q masks it to 0 until the
    // first fetch after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            ram_q[{wr_bank_q, w_wr_addr}] <= i_write_data;
        end
        if (w_fetch) begin
            ram_rd_q <= ram_q[{rd_bank_q, rd_ptr_q[ADDR_WIDTH-1:0]}];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_parser_ready                 = w_ready;
        o_parser_current_empty         = w_cur_empty;
        o_parser_current_memory_full   = overflow_q || !w_ready;
        o_dispatch_tx_packet_available = w_avail;
        o_dispatch_tx_fifo_empty       = w_fifo_empty;
        o_dispatch_tx_fifo_rd_data     = rd_data_zero_q ? 64'd0 : ram_rd_q;
        o_dispatch_tx_bytes_last_word  = w_avail ? bytes_last_q[rd_bank_q] : 4'd0;
        o_packets_queued               = queued_q;
        o_error                        = error_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_nts_tx_buffer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_nts_tx_buffer_multi
// Description : Self-checking bench for nts_tx_buffer_multi (ADDR_WIDTH=3,
//               BANK_BITS=2). Length vectors from a table, plus hand-written
//               corner-case sequences. Fetched words are checked against a
//               scoreboard fed from a bench-side copy of the written data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nts_tx_buffer_multi;

    localparam int AW = 3;
    localparam int BB = 2;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr_en, internal, upd, done, clr, rd_en, pkt_read;
    logic [63:0]   wdata;
    logic [AW-1:0] hi;
    logic [2:0]    lo;
    logic          ready, cur_empty, mem_full, avail, fifo_empty, err;
    logic [63:0]   rdata;
    logic [3:0]    blw;
    logic [BB:0]   queued;

    nts_tx_buffer_multi #(.ADDR_WIDTH(AW), .BANK_BITS(BB)) dut (
        .i_clk                          (clk),
        .i_areset                       (rst),
        .i_write_en                     (wr_en),
        .i_write_data                   (wdata),
        .i_address_internal             (internal),
        .i_address_hi                   (hi),
        .i_address_lo                   (lo),
        .i_parser_update_length         (upd),
        .i_parser_done                  (done),
        .i_parser_clear                 (clr),
        .o_parser_ready                 (ready),
        .o_parser_current_empty         (cur_empty),
        .o_parser_current_memory_full   (mem_full),
        .o_dispatch_tx_packet_available (avail),
        .o_dispatch_tx_fifo_empty       (fifo_empty),
        .i_dispatch_tx_fifo_rd_en       (rd_en),
        .o_dispatch_tx_fifo_rd_data     (rdata),
        .o_dispatch_tx_bytes_last_word  (blw),
        .i_dispatch_tx_packet_read      (pkt_read),
        .o_packets_queued               (queued),
        .o_error                        (err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;

    // Bench-side model of what each bank should contain
    logic [63:0] model_mem [4][8];
    logic [1:0]  m_wr_bank, m_rd_bank;
    logic [2:0]  m_wr_ptr, m_rd_ptr;
    logic [63:0] sb [$];

    typedef struct {
        logic [2:0] hi;
        logic [2:0] lo;
        int         n_wr;
        logic [3:0] exp_blw;
        int         exp_wc;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_wr_bank = '0; m_rd_bank = '0; m_wr_ptr = '0; m_rd_ptr = '0;
        sb.delete();
    endtask

    task automatic write_int(input logic [63:0] d, input bit exp_accept);
        wr_en = 1'b1; internal = 1'b1; wdata = d;
        tick();
        wr_en = 1'b0; internal = 1'b0;
        if (exp_accept) begin
            model_mem[m_wr_bank][m_wr_ptr] = d;
            m_wr_ptr++;
        end
    endtask

    task automatic set_len(input logic [2:0] h, input logic [2:0] l);
        upd = 1'b1; hi = h; lo = l;
        tick();
        upd = 1'b0; hi = '0; lo = '0;
    endtask

    task automatic do_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        m_wr_bank++;
        m_wr_ptr = '0;
    endtask

    task automatic do_release();
        pkt_read = 1'b1;
        tick();
        pkt_read = 1'b0;
        m_rd_bank++;
        m_rd_ptr = '0;
    endtask

    task automatic fetch(input string name);
        logic [63:0] exp;
        sb.push_back(model_mem[m_rd_bank][m_rd_ptr]);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        m_rd_ptr++;
        exp = sb.pop_front();
        check(name, rdata, exp);
    endtask

    // Fetch until fifo_empty (bounded), then check the word count seen
    task automatic drain(input string name, input int exp_wc);
        int n = 0;
        while (!fifo_empty && n < 16) begin
            fetch({name, "_data"});
            n++;
        end
        check({name, "_count"}, 64'(n), 64'(exp_wc));
        check({name, "_fifo_empty"}, 64'(fifo_empty), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"},     64'(ready),      64'd1);
        check({name, "_cur_empty"}, 64'(cur_empty),  64'd1);
        check({name, "_avail"},     64'(avail),      64'd0);
        check({name, "_fifo_emp"},  64'(fifo_empty), 64'd1);
        check({name, "_queued"},    64'(queued),     64'd0);
        check({name, "_mem_full"},  64'(mem_full),   64'd0);
        check({name, "_error"},     64'(err),        64'd0);
        check({name, "_rd_data"},   rdata,           64'd0);
        check({name, "_blw"},       64'(blw),        64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] last;
        rst = 1'b1; wr_en = 0; internal = 0; upd = 0; done = 0; clr = 0;
        rd_en = 0; pkt_read = 0; wdata = '0; hi = '0; lo = '0;

        //            hi    lo    n_wr blw  wc
        vecs[0] = '{3'd2, 3'd5, 3, 4'd5, 3};
        vecs[1] = '{3'd3, 3'd0, 3, 4'd8, 3};
        vecs[2] = '{3'd0, 3'd0, 1, 4'd0, 0};
        vecs[3] = '{3'd0, 3'd1, 1, 4'd1, 1};
        vecs[4] = '{3'd7, 3'd7, 8, 4'd7, 8};
        vecs[5] = '{3'd1, 3'd0, 1, 4'd8, 1};

        tick();
        do_reset();
        check_reset_outputs("reset");

        // packet_read with nothing available: error only
        do_release();
        m_rd_bank = '0;
        check("bad_release_error", 64'(err), 64'd1);
        check("bad_release_queued", 64'(queued), 64'd0);
        check("bad_release_avail", 64'(avail), 64'd0);
        do_reset();

        // Length table, rotating through all banks
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < vecs[i].n_wr; w++)
                write_int({8'(8'hA0 + i), 24'(w), $urandom}, 1'b1);
            set_len(vecs[i].hi, vecs[i].lo);
            do_done();
            check($sformatf("vec%0d_avail", i), 64'(avail), 64'd1);
            check($sformatf("vec%0d_blw", i), 64'(blw), 64'(vecs[i].exp_blw));
            drain($sformatf("vec%0d", i), vecs[i].exp_wc);
            do_release();
            check($sformatf("vec%0d_queued", i), 64'(queued), 64'd0);
        end
        check("table_error", 64'(err), 64'd0);

        // All four banks queued, no reads
        do_reset();
        for (int p = 0; p < 4; p++) begin
            write_int({32'hB000_0000, 32'(p)}, 1'b1);
            do_done();
        end
        check("full_queued", 64'(queued), 64'd4);
        check("full_ready", 64'(ready), 64'd0);
        check("full_mem_full", 64'(mem_full), 64'd1);
        check("full_default_blw", 64'(blw), 64'd8);
        check("full_error_before", 64'(err), 64'd0);
        write_int(64'hDEAD, 1'b0);
        check("full_write_error", 64'(err), 64'd1);
        drain("full_pkt0", 1);
        do_release();
        check("full_release_ready", 64'(ready), 64'd1);
        check("full_release_queued", 64'(queued), 64'd3);
        check("full_release_avail", 64'(avail), 64'd1);

        // Overrun at depth 8
        do_reset();
        for (int w = 0; w < 8; w++) write_int({32'hC000_0000, 32'(w * 3 + 1)}, 1'b1);
        check("ovf_mem_full", 64'(mem_full), 64'd1);
        check("ovf_error_before", 64'(err), 64'd0);
        write_int(64'hBAD0_BAD0, 1'b0);
        check("ovf_error", 64'(err), 64'd1);
        do_done();
        check("ovf_blw", 64'(blw), 64'd8);
        drain("ovf", 8);
        last = model_mem[0][7];
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check("rd_en_when_empty_ignored", rdata, last);
        do_release();

        // Clear beats write and done in the same cycle
        do_reset();
        write_int(64'h1111_2222, 1'b1);
        clr = 1'b1; wr_en = 1'b1; internal = 1'b1; done = 1'b1; wdata = 64'h3333;
        tick();
        clr = 1'b0; wr_en = 1'b0; internal = 1'b0; done = 1'b0;
        m_wr_ptr = '0;
        check("clear_cur_empty", 64'(cur_empty), 64'd1);
        check("clear_queued", 64'(queued), 64'd0);
        check("clear_avail", 64'(avail), 64'd0);
        check("clear_error", 64'(err), 64'd0);
        write_int(64'h4444_5555_6666_7777, 1'b1);
        do_done();
        drain("after_clear", 1);
        do_release();

        // Done on bank 1 and release of bank 0 together
        do_reset();
        write_int(64'hAAAA_0000, 1'b1);
        do_done();
        write_int(64'hBBBB_1111, 1'b1);
        done = 1'b1; pkt_read = 1'b1;
        tick();
        done = 1'b0; pkt_read = 1'b0;
        m_wr_bank++; m_wr_ptr = '0; m_rd_bank++; m_rd_ptr = '0;
        check("both_queued", 64'(queued), 64'd1);
        check("both_avail", 64'(avail), 64'd1);
        drain("both_bank1", 1);
        do_release();

        // Reset in the middle of a read
        do_reset();
        for (int w = 0; w < 4; w++) write_int({32'hD000_0000, 32'(w)}, 1'b1);
        do_done();
        fetch("midread_first");
        rd_en = 1'b1;
        do_reset();
        rd_en = 1'b0;
        check_reset_outputs("midread_reset");
        write_int(64'h0123_4567_89AB_CDEF, 1'b1);
        do_done();
        check("post_reset_avail", 64'(avail), 64'd1);
        drain("post_reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
